// File: rtl/dmem_wait_unit_if.sv
// Data-memory request/response bundle between the MEM stage and dmem_wait_unit.
// The pipeline side drives the request fields; the memory side drives the results and ready.
interface dmem_wait_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  wr_en;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  ready;
    logic                  done;

    modport master (
        output wr_en, rd_en, address, wr_data,
        input  rd_data, ready, done
    );

    modport slave (
        input  wr_en, rd_en, address, wr_data,
        output rd_data, ready, done
    );
endinterface

// File: rtl/dmem_wait_unit.sv
// Multi-cycle data memory for the MEM stage: latches a request, waits LATENCY busy cycles,
// performs the access, then pulses done for one cycle while ready releases the pipeline stall.
module dmem_wait_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int RAM_DEPTH  = 256,
    parameter int LATENCY    = 2
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    dmem_wait_unit_if.slave  bus
);
    localparam int IDX_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int CNT_W = 4;

    if ((RAM_DEPTH < 2) || ((RAM_DEPTH & (RAM_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("dmem_wait_unit: RAM_DEPTH must be a power of two of at least 2");
    end
    if ((LATENCY < 1) || (LATENCY > 15)) begin : g_bad_latency
        $error("dmem_wait_unit: LATENCY must be in the range 1..15");
    end
    if (ADDR_WIDTH < IDX_W + 2) begin : g_bad_addr
        $error("dmem_wait_unit: ADDR_WIDTH too narrow for RAM_DEPTH");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  op_wr_q, op_wr_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  done_q;

    logic                  req;
    logic                  mem_we;
    logic                  rd_load;
    logic                  ready;

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    assign req = bus.rd_en | bus.wr_en;

    // Byte offset and bits above the word index are deliberately dropped (wrap-around).
    logic unused_addr_bits;
    if (ADDR_WIDTH > IDX_W + 2) begin : g_addr_hi
        assign unused_addr_bits = ^{bus.address[ADDR_WIDTH-1:IDX_W+2], bus.address[1:0]};
    end else begin : g_addr_lo
        assign unused_addr_bits = ^bus.address[1:0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        mem_we  = 1'b0;
        rd_load = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_BUSY;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    // A simultaneous read and write is treated as a write.
                    op_wr_d = bus.wr_en;
                    idx_d   = bus.address[IDX_W+1:2];
                    wdata_d = bus.wr_data;
                end
            end
            S_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = S_DONE;
                    mem_we  = op_wr_q;
                    rd_load = ~op_wr_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Reset forces IDLE, so ready collapses to ~req while reset is held.
    always_comb begin
        ready = ((state_q == S_IDLE) & ~req) | (state_q == S_DONE);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_wr_q   <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            rd_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            done_q  <= (state_d == S_DONE);
            if (rd_load) begin
                rd_data_q <= mem[idx_q];
            end
        end
    end

    // Array is never reset; a write interrupted by reset never reaches here because state is IDLE.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign bus.ready   = ready;
    assign bus.done    = done_q;
    assign bus.rd_data = rd_data_q;

endmodule

// File: tb/tb_dmem_wait_unit.sv
// Directed scoreboard bench for dmem_wait_unit: one instance at LATENCY=2, one at LATENCY=1.
// Expected read data comes from a bench-side memory model and is queued when each access issues.
module tb_dmem_wait_unit;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    dmem_wait_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) ifa ();
    dmem_wait_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) ifb ();

    dmem_wait_unit #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .RAM_DEPTH(256), .LATENCY(2)
    ) u_dut_a (
        .clk_i   (clk),
        .reset_ni(rst_n),
        .bus     (ifa)
    );

    dmem_wait_unit #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .RAM_DEPTH(256), .LATENCY(1)
    ) u_dut_b (
        .clk_i   (clk),
        .reset_ni(rst_n),
        .bus     (ifb)
    );

    int unsigned total  = 0;
    int unsigned passed = 0;

    logic [31:0] mem_a [int];
    logic [31:0] mem_b [int];
    logic [31:0] rdm   [2];
    logic [31:0] q_a   [$];
    logic [31:0] q_b   [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) begin
            passed++;
        end else begin
            $error("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit b, input bit wr, input bit rd,
                         input logic [31:0] addr, input logic [31:0] data);
        if (b) begin
            ifb.wr_en = wr; ifb.rd_en = rd; ifb.address = addr; ifb.wr_data = data;
        end else begin
            ifa.wr_en = wr; ifa.rd_en = rd; ifa.address = addr; ifa.wr_data = data;
        end
    endtask

    task automatic sample(input bit b, output logic rdy, output logic dn, output logic [31:0] rdd);
        if (b) begin
            rdy = ifb.ready; dn = ifb.done; rdd = ifb.rd_data;
        end else begin
            rdy = ifa.ready; dn = ifa.done; rdd = ifa.rd_data;
        end
    endtask

    task automatic pop_exp(input bit b, input string tag, output logic [31:0] exp);
        int unsigned sz;
        sz = b ? q_b.size() : q_a.size();
        exp = 'x;
        total++;
        assert (sz != 0) begin
            passed++;
            exp = b ? q_b.pop_front() : q_a.pop_front();
        end else begin
            $error("FAIL %s scoreboard empty got=0 expected=1", tag);
        end
    endtask

    // Called at posedge+1 with the DUT idle; returns at posedge+1 of the following idle cycle.
    task automatic access(input bit b, input bit wr, input bit rd,
                          input logic [31:0] addr, input logic [31:0] data,
                          input bit scramble, input string tag);
        int unsigned lat;
        int          idx;
        logic        rdy, dn;
        logic [31:0] rdd, exp;
        lat = b ? 1 : 2;
        idx = int'((addr >> 2) & 32'hFF);
        drive(b, wr, rd, addr, data);
        if (wr) begin
            if (b) mem_b[idx] = data; else mem_a[idx] = data;
        end else begin
            rdm[b] = b ? mem_b[idx] : mem_a[idx];
        end
        if (b) q_b.push_back(rdm[b]); else q_a.push_back(rdm[b]);
        for (int unsigned c = 0; c <= lat + 1; c++) begin
            if (c == 1 && scramble) drive(b, wr, rd, ~addr, ~data);
            if (c == lat + 1) drive(b, 1'b0, 1'b0, '0, '0);
            @(negedge clk);
            sample(b, rdy, dn, rdd);
            if (c <= lat) begin
                chk($sformatf("%s.ready.c%0d", tag, c), 32'(rdy), 32'd0);
                chk($sformatf("%s.done.c%0d", tag, c), 32'(dn), 32'd0);
            end else begin
                chk($sformatf("%s.ready.c%0d", tag, c), 32'(rdy), 32'd1);
                chk($sformatf("%s.done.c%0d", tag, c), 32'(dn), 32'd1);
                pop_exp(b, tag, exp);
                chk($sformatf("%s.rd_data", tag), rdd, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic        rdy, dn;
        logic [31:0] rdd, exp;

        rdm[0] = '0;
        rdm[1] = '0;
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #1;
        sample(0, rdy, dn, rdd);
        chk("rst.ready_noreq", 32'(rdy), 32'd1);
        chk("rst.done", 32'(dn), 32'd0);
        chk("rst.rd_data", rdd, 32'd0);
        ifa.rd_en = 1'b1;
        #1;
        chk("rst.ready_req", 32'(ifa.ready), 32'd0);
        ifa.rd_en = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int unsigned i = 0; i < 5; i++) begin
            @(negedge clk);
            sample(0, rdy, dn, rdd);
            chk($sformatf("idle.ready.%0d", i), 32'(rdy), 32'd1);
            chk($sformatf("idle.done.%0d", i), 32'(dn), 32'd0);
            chk($sformatf("idle.rd_data.%0d", i), rdd, 32'd0);
            @(posedge clk); #1;
        end

        access(0, 1'b1, 1'b0, 32'h40, 32'hDEADBEEF, 1'b0, "wr40");
        access(0, 1'b0, 1'b1, 32'h40, 32'h0, 1'b0, "rd40");

        access(0, 1'b1, 1'b0, 32'h400, 32'h11111111, 1'b0, "wr400");
        access(0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, "rd0");
        access(0, 1'b0, 1'b1, 32'h3, 32'h0, 1'b0, "rd3");

        access(0, 1'b1, 1'b1, 32'h8, 32'h5A5A5A5A, 1'b0, "rdwr8");
        access(0, 1'b0, 1'b1, 32'h8, 32'h0, 1'b0, "rd8");

        access(0, 1'b1, 1'b0, 32'h20, 32'hA5A5F00F, 1'b1, "wr20_scr");
        access(0, 1'b0, 1'b1, 32'h20, 32'h0, 1'b0, "rd20");

        // Interrupt a write with reset while it is in BUSY.
        access(0, 1'b1, 1'b0, 32'h10, 32'hCAFEF00D, 1'b0, "wr10");
        drive(0, 1'b1, 1'b0, 32'h10, 32'h12345678);
        @(negedge clk);
        chk("rstw.ready_c0", 32'(ifa.ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        sample(0, rdy, dn, rdd);
        chk("rstw.ready_req", 32'(rdy), 32'd0);
        chk("rstw.done", 32'(dn), 32'd0);
        chk("rstw.rd_data", rdd, 32'd0);
        drive(0, 1'b0, 1'b0, '0, '0);
        #1;
        chk("rstw.ready_noreq", 32'(ifa.ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        rdm[0] = '0;
        rdm[1] = '0;
        @(posedge clk); #1;
        access(0, 1'b0, 1'b1, 32'h10, 32'h0, 1'b0, "rd10_after_rst");

        // LATENCY=1 instance: seed one word, then hold a read request across two accesses.
        access(1, 1'b1, 1'b0, 32'h24, 32'h0BADCAFE, 1'b0, "b.wr24");
        access(1, 1'b0, 1'b1, 32'h24, 32'h0, 1'b0, "b.rd24");
        drive(1, 1'b0, 1'b1, 32'h24, 32'h0);
        for (int unsigned c = 0; c < 6; c++) begin
            if (c == 5) drive(1, 1'b0, 1'b0, '0, '0);
            @(negedge clk);
            sample(1, rdy, dn, rdd);
            chk($sformatf("b2b.ready.c%0d", c), 32'(rdy), (c == 2 || c == 5) ? 32'd1 : 32'd0);
            chk($sformatf("b2b.done.c%0d", c), 32'(dn), (c == 2 || c == 5) ? 32'd1 : 32'd0);
            if (c == 2 || c == 5) begin
                exp = mem_b[9];
                chk($sformatf("b2b.rd_data.c%0d", c), rdd, exp);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        sample(1, rdy, dn, rdd);
        chk("b2b.idle.ready", 32'(rdy), 32'd1);
        chk("b2b.idle.done", 32'(dn), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/dmem_wait_unit.md
# dmem_wait_unit

Multi-cycle data-memory block for the MEM stage of the five-stage pipeline. It takes the `memread_m`/`memwrite_m` request, `execout_m` address and `writedata_m` store data from the EXE/MEM register. It models a parameterised access latency and returns `memready_m` to the hazard detector, which holds the pipeline until the access completes. Load data goes to the MEM/WB register.

## Interface
- `DATA_WIDTH`, 32: data word width.
- `ADDR_WIDTH`, 32: byte-address input width.
- `RAM_DEPTH`, 256: number of words; must be a power of two.
- `LATENCY`, 2: number of BUSY cycles per access; legal range 1–15.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `wr_en` input 1: store request (`memwrite_m`).
- `rd_en` input 1: load request (`memread_m`).
- `address` input ADDR_WIDTH: byte address (`execout_m`).
- `wr_data` input DATA_WIDTH: store data (`writedata_m`).
- `rd_data` output DATA_WIDTH: registered load result.
- `ready` output 1: high when no access is outstanding; low stalls the pipeline (`memready_m`).
- `done` output 1: one-cycle pulse when an access completes.

## Operation
- **Word index:** `address[log2(RAM_DEPTH)+1:2]`.
  - `address[1:0]` is ignored.
  - Upper bits are ignored, so out-of-range addresses wrap modulo `RAM_DEPTH`.
- **Request:** `req = rd_en | wr_en`.
  - If `wr_en` and `rd_en` are both high, the access is a write; `rd_data` is unchanged.
- **FSM states:** IDLE, BUSY, DONE.
  - **IDLE:**
    - `req=0`: stay in IDLE.
    - `req=1`: at the next edge, latch op, word index and `wr_data`; load `cnt = LATENCY-1`; go to BUSY.
  - **BUSY:**
    - `cnt != 0`: decrement `cnt`.
    - `cnt == 0`: perform the access at the edge. A write updates the array; a read loads `rd_data` from the array. Go to DONE.
    - Input changes during BUSY are ignored; only the latched values are used.
  - **DONE:** lasts exactly one cycle, then unconditionally goes to IDLE.
- **`ready` (combinational):** `(state==IDLE & ~req) | state==DONE`.
  - `ready` goes low in the same cycle a request appears, so the hazard unit stalls immediately.
- **`done` (registered):** `state==DONE`.
- **`rd_data`:** holds the last read result until the next read completes.
- **Back-to-back accesses:** a request still asserted in the IDLE cycle after DONE is a new access.
- **Reset (`reset=0`), asynchronous and at any time:**
  - state ← IDLE, `cnt` ← 0, `rd_data` ← 0, `done` ← 0.
  - A pending write is discarded; the array is not written.
  - Array contents are not reset.
  - While reset is asserted, `ready = ~req`.

## Timing
- Request first presented in cycle 0 (state IDLE):
  - `ready` is low in cycles 0 … LATENCY.
  - In cycle LATENCY+1: `ready=1`, `done=1`, and `rd_data` is valid.
- Total stall is LATENCY+1 cycles; the pipeline advances at the end of the DONE cycle.
- With `LATENCY=1`: BUSY is 1 cycle and the result is visible in cycle 2.
- Write visibility: the write commits at the BUSY→DONE edge, so a read issued in the following IDLE cycle returns the new data.
- Reset output values: `rd_data=0`, `done=0`, state IDLE.

## Test plan
- **Idle behaviour:** reset released, `rd_en=wr_en=0` for 5 cycles → `ready=1` and `done=0` every cycle; `rd_data=0`.
- **Write then read, `LATENCY=2`:**
  - Write `0xDEADBEEF` to `0x40` → `ready` low for exactly 3 cycles; `done` pulses once in cycle 3.
  - Then read `0x40` → `rd_data=0xDEADBEEF` in its DONE cycle.
- **Wrap-around and aliasing:**
  - Write `0x11111111` to `0x400` (wraps to word 0 with `RAM_DEPTH=256`); read `0x0` → `0x11111111`.
  - Read `0x003` → same word, `0x11111111`.
- **Simultaneous read and write:** `rd_en=wr_en=1`, address `0x8`, data `0x5A5A5A5A` → treated as a write; `rd_data` keeps its prior value; a later read of `0x8` returns `0x5A5A5A5A`.
- **Inputs changed mid-access:** change `address` and `wr_data` during BUSY → the originally latched address and data are written.
- **Reset mid-write:**
  - Assert reset during BUSY of a write of `0x12345678` to `0x10` → outputs go immediately to `ready=~req`, `done=0`, `rd_data=0`.
  - After release, read `0x10` → old contents, not `0x12345678`.
- **Back-to-back accesses, `LATENCY=1`:** two reads held continuously → two distinct `done` pulses 3 cycles apart, with `ready=1` only in each DONE cycle.
